fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Parametrised successor to the fixed 6-way FIR operand mux. Holds an NTAPS-deep
//  delay line of signed samples, accepts one new sample per FIR evaluation and
//  streams all NTAPS operands, oldest first, to the downstream serial MAC.
//  Valid/ready handshakes on both sides replace the externally driven selector.
//  Sits between the sample source (ADC/test ROM) and the MAC/coefficient ROM.
// PARAMETERS
//  BitsX  16                   sample width, two's complement
//  NTAPS  6                    taps = delay-line length incl. newest; legal range >= 2
//  IDXW   $clog2(NTAPS)        tap-index width (derived, do not override)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      synchronous reset, active low
//  flush     in   1      sync clear of delay line + abort of current burst
//  in_valid  in   1      new sample offered
//  in_ready  out  1      block can accept a sample (high only in IDLE)
//  in_data   in   BitsX  signed sample x(k)
//  x_valid   out  1      operand beat valid
//  x_ready   in   1      MAC accepts beat
//  x_data    out  BitsX  signed operand x(k-NTAPS+1+x_idx)
//  x_idx     out  IDXW   coefficient index for this beat, 0..NTAPS-1
//  x_first   out  1      beat is idx 0 (MAC clears accumulator)
//  x_last    out  1      beat is idx NTAPS-1 (MAC publishes result)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all taps=0, state=IDLE, x_valid=0, x_data=0, x_idx=0,
//   x_first=0, x_last=0; in_ready=1 from first cycle after reset release.
//  Delay line tap[0..NTAPS-1], tap[0]=newest. Accept = in_valid&&in_ready:
//   tap[0]<=in_data, tap[j]<=tap[j-1]; oldest sample dropped.
//  FSM: IDLE -accept-> SEQ; SEQ -(x_valid&&x_ready&&x_last)-> IDLE; any -flush-> IDLE.
//  in_ready = (state==IDLE); combinational from state only, no path from in_valid.
//  Latency: sample accepted at edge t -> first beat (idx 0) valid in cycle after t.
//  Beat order idx 0..NTAPS-1: x_data = tap[NTAPS-1-idx] of the post-shift line,
//   i.e. oldest first, newest (just-accepted sample) last.
//  All x_* outputs registered. Hold rule: while x_valid&&!x_ready, x_data, x_idx,
//   x_first, x_last stay stable. Index advances only on x_valid&&x_ready.
//  Max throughput: NTAPS beats per sample + 1 IDLE cycle; next accept happens no
//   earlier than the cycle after last-beat handshake.
//  x_first = x_valid&&(x_idx==0); x_last = x_valid&&(x_idx==NTAPS-1); both 0 when
//   x_valid=0. Index counter returns to 0 after last beat (no wrap beyond NTAPS-1).
//  flush (priority over accept and handshake in same cycle): taps<=0, state<=IDLE,
//   x_valid<=0, x_idx<=0 next edge; partially sent burst abandoned, MAC sees no x_last.
//   flush with in_valid in IDLE: sample NOT accepted (in_ready forced 0 that cycle).
//  rst_n has priority over flush. Reset mid-burst behaves like flush + output clear.
//  No arithmetic on data: samples passed bit-exact, sign preserved, no extension.
// STRUCTURE
//  Package fir_pkg: typedef enum logic {IDLE, SEQ} fir_seq_state_t; default
//   BitsX/NTAPS localparams shared with MAC and coefficient ROM.
//  Sub-module fir_delay_line #(BitsX,NTAPS): shift-in on en, sync clear on clr,
//   exposes packed tap array; sequencer owns FSM, index counter, output regs.
// TESTING
//  Reset: hold rst_n=0 3 cycles, release -> in_ready=1, x_valid=0, all outputs 0.
//  NTAPS=6, push 1..6 with x_ready=1 -> sixth burst beats x_data = 1,2,3,4,5,6,
//   x_idx 0..5, x_first on idx0, x_last on idx5; 1st burst = 0,0,0,0,0,1.
//  Backpressure: toggle x_ready 1/0 randomly each cycle on sample -32768 ->
//   no beat lost/duplicated, outputs stable while stalled, in_ready=0 until x_last.
//  Signed data: push 16'h8000, 16'h7FFF, -1 -> beats show exact bit patterns.
//  Flush at idx3 of a burst with in_valid=1 -> x_valid=0 next cycle, no x_last,
//   in_ready=1, next sample 9 gives burst 0,0,0,0,0,9.
//  NTAPS=2 and NTAPS=17 builds: burst length and x_last position match NTAPS.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: sequencer state encoding and the
// default sample width / tap count also used by the MAC and coefficient ROM.
package fir_pkg;

  typedef enum logic {IDLE, SEQ} fir_seq_state_t;

  localparam int FIR_BITSX = 16;
  localparam int FIR_NTAPS = 6;

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep delay line of samples. tap[0] holds the newest sample; a shift
// pushes din_i into tap[0] and drops the oldest entry. clr_i wins over en_i.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int BitsX = FIR_BITSX,
  parameter int NTAPS = FIR_NTAPS
) (
  input  logic                         clk,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [BitsX-1:0]             din_i,
  output logic [NTAPS-1:0][BitsX-1:0]  taps_o
);

  logic [NTAPS-1:0][BitsX-1:0] taps_q;
  logic [NTAPS-1:0][BitsX-1:0] taps_d;

  // Next-state: clear, shift toward older taps, or hold.
  always_comb begin
    taps_d = taps_q;
    if (clr_i) begin
      taps_d = '0;
    end else if (en_i) begin
      taps_d = {taps_q[NTAPS-2:0], din_i};
    end
  end

  // Tap storage register.
  always_ff @(posedge clk) begin
    taps_q <= taps_d;
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Accepts one sample per FIR evaluation into a delay line, then streams all
// NTAPS operands oldest-first to the serial MAC with a valid/ready handshake.
// All x_* outputs come straight from registers.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int BitsX = FIR_BITSX,
  parameter int NTAPS = FIR_NTAPS,
  parameter int IDXW  = $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [BitsX-1:0]  in_data,
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic signed [BitsX-1:0]  x_data,
  output logic [IDXW-1:0]          x_idx,
  output logic                     x_first,
  output logic                     x_last
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

  fir_seq_state_t              state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        x_valid_q, x_valid_d;
  logic signed [BitsX-1:0]     x_data_q, x_data_d;
  logic                        x_first_q, x_first_d;
  logic                        x_last_q, x_last_d;

  logic [NTAPS-1:0][BitsX-1:0] taps;
  logic                        accept;
  logic                        dl_clr;
  logic [IDXW-1:0]             idx_nxt;

  // Beat idx reads tap NTAPS-1-idx so the oldest sample goes out first.
  function automatic logic [IDXW-1:0] rev_idx(input logic [IDXW-1:0] i);
    return LAST_IDX - i;
  endfunction

  // Flush blocks acceptance in the same cycle so a flushed sample is never taken.
  assign in_ready = (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;
  assign dl_clr   = flush || !rst_n;
  assign idx_nxt  = idx_q + IDXW'(1);

  fir_delay_line #(
    .BitsX (BitsX),
    .NTAPS (NTAPS)
  ) u_delay_line (
    .clk    (clk),
    .en_i   (accept),
    .clr_i  (dl_clr),
    .din_i  (in_data),
    .taps_o (taps)
  );

  // FSM, index counter and output next-state. On accept the line is still
  // pre-shift, so the post-shift oldest tap is today's tap[NTAPS-2].
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_valid_d = x_valid_q;
    x_data_d  = x_data_q;
    if (flush) begin
      state_d   = IDLE;
      idx_d     = '0;
      x_valid_d = 1'b0;
      x_data_d  = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_d   = SEQ;
        idx_d     = '0;
        x_valid_d = 1'b1;
        x_data_d  = taps[NTAPS-2];
      end
    end else if (x_valid_q && x_ready) begin
      if (x_last_q) begin
        state_d   = IDLE;
        idx_d     = '0;
        x_valid_d = 1'b0;
        x_data_d  = '0;
      end else begin
        idx_d    = idx_nxt;
        x_data_d = taps[rev_idx(idx_nxt)];
      end
    end
    x_first_d = x_valid_d && (idx_d == '0);
    x_last_d  = x_valid_d && (idx_d == LAST_IDX);
  end

  // State and output registers; reset overrides flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_valid_q <= 1'b0;
      x_data_q  <= '0;
      x_first_q <= 1'b0;
      x_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_valid_q <= x_valid_d;
      x_data_q  <= x_data_d;
      x_first_q <= x_first_d;
      x_last_q  <= x_last_d;
    end
  end

  assign x_valid = x_valid_q;
  assign x_data  = x_data_q;
  assign x_idx   = idx_q;
  assign x_first = x_first_q;
  assign x_last  = x_last_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: NTAPS=6 main instance plus NTAPS=2
// and NTAPS=17 instances for burst-length checks.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, x_ready;
  logic [15:0] in_data;
  logic        in_valid6, in_valid2, in_valid17;

  logic        in_ready6, x_valid6, x_first6, x_last6;
  logic [15:0] x_data6;
  logic [2:0]  x_idx6;
  logic        in_ready2, x_valid2, x_first2, x_last2;
  logic [15:0] x_data2;
  logic [0:0]  x_idx2;
  logic        in_ready17, x_valid17, x_first17, x_last17;
  logic [15:0] x_data17;
  logic [4:0]  x_idx17;

  fir_tap_sequencer #(.BitsX(16), .NTAPS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_data(in_data), .x_valid(x_valid6), .x_ready(x_ready), .x_data(x_data6),
    .x_idx(x_idx6), .x_first(x_first6), .x_last(x_last6));

  fir_tap_sequencer #(.BitsX(16), .NTAPS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .x_valid(x_valid2), .x_ready(x_ready), .x_data(x_data2),
    .x_idx(x_idx2), .x_first(x_first2), .x_last(x_last2));

  fir_tap_sequencer #(.BitsX(16), .NTAPS(17)) dut17 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid17), .in_ready(in_ready17),
    .in_data(in_data), .x_valid(x_valid17), .x_ready(x_ready), .x_data(x_data17),
    .x_idx(x_idx17), .x_first(x_first17), .x_last(x_last17));

  int errors = 0;
  int checks = 0;

  // Capture of one NTAPS=6 burst
  logic [15:0] cap_data [0:31];
  int          cap_idx  [0:31];
  bit          cap_first[0:31];
  bit          cap_last [0:31];
  int          cap_n;
  int          hold_err, inr_err, wait_cyc;
  bit          tmo, lat_ok;

  // Offer one sample to dut6 and record the resulting burst at handshakes.
  task automatic send6(input logic [15:0] s, input bit rand_ready);
    bit          r, stall, done;
    logic [15:0] pd;
    logic [2:0]  pi;
    bit          pf, pl;
    cap_n = 0; hold_err = 0; inr_err = 0; wait_cyc = 0; tmo = 1'b0;
    stall = 1'b0; done = 1'b0; pd = '0; pi = '0; pf = 1'b0; pl = 1'b0;
    while (!in_ready6 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    in_data = s; in_valid6 = 1'b1; x_ready = 1'b0;
    @(negedge clk);
    in_valid6 = 1'b0;
    lat_ok = x_valid6 && (x_idx6 == 3'd0) && x_first6;
    for (int c = 0; c < 200; c++) begin
      if (stall && (!x_valid6 || x_data6 !== pd || x_idx6 !== pi || x_first6 !== pf || x_last6 !== pl))
        hold_err++;
      if (x_valid6 && in_ready6) inr_err++;
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      x_ready = r;
      if (x_valid6 && r && cap_n < 32) begin
        cap_data[cap_n] = x_data6; cap_idx[cap_n] = int'(x_idx6);
        cap_first[cap_n] = x_first6; cap_last[cap_n] = x_last6;
        cap_n++;
        if (x_last6) done = 1'b1;
      end
      stall = x_valid6 && !r;
      pd = x_data6; pi = x_idx6; pf = x_first6; pl = x_last6;
      @(negedge clk);
      if (done) break;
    end
    if (!done) tmo = 1'b1;
    x_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready6 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready6); end
    checks++; if (x_valid6 !== 1'b0) begin errors++; $display("FAIL reset_x_valid: got %b want 0", x_valid6); end
    checks++; if (x_data6 !== 16'h0) begin errors++; $display("FAIL reset_x_data: got %h want 0000", x_data6); end
    checks++; if (x_idx6 !== 3'd0) begin errors++; $display("FAIL reset_x_idx: got %0d want 0", x_idx6); end
    checks++; if (x_first6 !== 1'b0 || x_last6 !== 1'b0) begin errors++; $display("FAIL reset_first_last: got %b%b want 00", x_first6, x_last6); end
    checks++; if (x_valid2 !== 1'b0 || x_valid17 !== 1'b0 || in_ready2 !== 1'b1 || in_ready17 !== 1'b1) begin
      errors++; $display("FAIL reset_other_builds: got v2=%b v17=%b r2=%b r17=%b want 0 0 1 1", x_valid2, x_valid17, in_ready2, in_ready17); end
  endtask

  task automatic test_sequence();
    logic [15:0] e1 [6];
    e1 = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    send6(16'd1, 1'b0);
    checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL seq_latency: got %b want 1", lat_ok); end
    checks++; if (cap_n != 6 || tmo) begin errors++; $display("FAIL seq_burst1_len: got %0d want 6", cap_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_data[i] !== e1[i]) begin errors++; $display("FAIL seq_burst1_data[%0d]: got %h want %h", i, cap_data[i], e1[i]); end
    end
    for (int k = 2; k <= 6; k++) begin
      send6(16'(k), 1'b0);
      checks++; if (wait_cyc != 0) begin errors++; $display("FAIL seq_back_to_back_wait: got %0d want 0", wait_cyc); end
    end
    checks++; if (cap_n != 6 || tmo) begin errors++; $display("FAIL seq_burst6_len: got %0d want 6", cap_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_data[i] !== 16'(i + 1)) begin errors++; $display("FAIL seq_burst6_data[%0d]: got %h want %h", i, cap_data[i], 16'(i + 1)); end
      checks++; if (cap_idx[i] != i) begin errors++; $display("FAIL seq_burst6_idx[%0d]: got %0d want %0d", i, cap_idx[i], i); end
      checks++; if (cap_first[i] !== (i == 0)) begin errors++; $display("FAIL seq_burst6_first[%0d]: got %b want %b", i, cap_first[i], (i == 0)); end
      checks++; if (cap_last[i] !== (i == 5)) begin errors++; $display("FAIL seq_burst6_last[%0d]: got %b want %b", i, cap_last[i], (i == 5)); end
    end
    checks++; if (in_ready6 !== 1'b1 || x_valid6 !== 1'b0) begin errors++; $display("FAIL seq_idle_after: got r=%b v=%b want 1 0", in_ready6, x_valid6); end
  endtask

  task automatic test_backpressure();
    logic [15:0] e [6];
    // Line before: newest 6 .. oldest 1; -32768 pushes out 1.
    e = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'h8000};
    send6(16'h8000, 1'b1);
    checks++; if (cap_n != 6 || tmo) begin errors++; $display("FAIL bp_len: got %0d want 6", cap_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_data[i] !== e[i] || cap_idx[i] != i) begin
        errors++; $display("FAIL bp_beat[%0d]: got %h/%0d want %h/%0d", i, cap_data[i], cap_idx[i], e[i], i); end
    end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_err); end
    checks++; if (inr_err != 0) begin errors++; $display("FAIL bp_in_ready: got %0d cycles high mid-burst want 0", inr_err); end
  endtask

  task automatic test_signed();
    logic [15:0] e [6];
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    e = '{16'h0, 16'h0, 16'h0, 16'h8000, 16'h7FFF, 16'hFFFF};
    send6(16'h8000, 1'b0);
    send6(16'h7FFF, 1'b0);
    send6(16'hFFFF, 1'b0);
    checks++; if (cap_n != 6 || tmo) begin errors++; $display("FAIL signed_len: got %0d want 6", cap_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_data[i] !== e[i]) begin errors++; $display("FAIL signed_data[%0d]: got %h want %h", i, cap_data[i], e[i]); end
    end
  endtask

  task automatic test_flush();
    int  n;
    bit  saw_last;
    saw_last = 1'b0;
    in_data = 16'd7; in_valid6 = 1'b1; x_ready = 1'b1;
    @(negedge clk);
    in_valid6 = 1'b0;
    n = 0;
    while (x_idx6 != 3'd3 && n < 20) begin
      if (x_last6) saw_last = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (x_valid6 !== 1'b1 || x_idx6 !== 3'd3) begin errors++; $display("FAIL flush_reach_idx3: got v=%b idx=%0d want 1 3", x_valid6, x_idx6); end
    flush = 1'b1; in_valid6 = 1'b1; in_data = 16'd9;
    #1;
    checks++; if (in_ready6 !== 1'b0) begin errors++; $display("FAIL flush_in_ready_low: got %b want 0", in_ready6); end
    @(negedge clk);
    checks++; if (x_valid6 !== 1'b0 || x_last6 !== 1'b0 || x_idx6 !== 3'd0) begin
      errors++; $display("FAIL flush_outputs: got v=%b l=%b idx=%0d want 0 0 0", x_valid6, x_last6, x_idx6); end
    flush = 1'b0; in_valid6 = 1'b0; x_ready = 1'b0;
    #1;
    checks++; if (in_ready6 !== 1'b1) begin errors++; $display("FAIL flush_in_ready_after: got %b want 1", in_ready6); end
    @(negedge clk);
    checks++; if (x_valid6 !== 1'b0 || saw_last) begin errors++; $display("FAIL flush_no_burst: got v=%b last_seen=%b want 0 0", x_valid6, saw_last); end
    send6(16'd9, 1'b0);
    checks++; if (cap_n != 6 || tmo) begin errors++; $display("FAIL flush_next_len: got %0d want 6", cap_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_data[i] !== ((i == 5) ? 16'd9 : 16'd0)) begin
        errors++; $display("FAIL flush_next_data[%0d]: got %h want %h", i, cap_data[i], ((i == 5) ? 16'd9 : 16'd0)); end
    end
  endtask

  task automatic test_ntaps();
    int          n, lidx;
    logic [15:0] d0, dl;
    bit          done;
    // NTAPS=2: line empty after flush, then 0055 then 0066
    for (int k = 0; k < 2; k++) begin
      in_data = (k == 0) ? 16'h0055 : 16'h0066; in_valid2 = 1'b1; x_ready = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      n = 0; lidx = -1; d0 = 'x; dl = 'x; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (x_valid2) begin
          if (n == 0) d0 = x_data2;
          n++;
          if (x_last2) begin done = 1'b1; lidx = int'(x_idx2); dl = x_data2; end
        end
        @(negedge clk);
      end
      checks++; if (n != 2 || lidx != 1) begin errors++; $display("FAIL ntaps2_len[%0d]: got n=%0d last_idx=%0d want 2 1", k, n, lidx); end
      checks++; if (d0 !== ((k == 0) ? 16'h0000 : 16'h0055) || dl !== in_data) begin
        errors++; $display("FAIL ntaps2_data[%0d]: got %h,%h want %h,%h", k, d0, dl, ((k == 0) ? 16'h0000 : 16'h0055), in_data); end
    end
    // NTAPS=17
    in_data = 16'h0123; in_valid17 = 1'b1; x_ready = 1'b1;
    @(negedge clk);
    in_valid17 = 1'b0;
    n = 0; lidx = -1; d0 = 'x; dl = 'x; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (x_valid17) begin
        if (n == 0) d0 = x_data17;
        n++;
        if (x_last17) begin done = 1'b1; lidx = int'(x_idx17); dl = x_data17; end
      end
      @(negedge clk);
    end
    x_ready = 1'b0;
    checks++; if (n != 17 || lidx != 16) begin errors++; $display("FAIL ntaps17_len: got n=%0d last_idx=%0d want 17 16", n, lidx); end
    checks++; if (d0 !== 16'h0000 || dl !== 16'h0123) begin errors++; $display("FAIL ntaps17_data: got %h,%h want 0000,0123", d0, dl); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; x_ready = 1'b0; in_data = '0;
    in_valid6 = 1'b0; in_valid2 = 1'b0; in_valid17 = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_backpressure();
    test_signed();
    test_flush();
    test_ntaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
